noc_conf_bus_arbiter: RTL and testbench

//  Shares the single NoC configuration bus (slot-table LUT writes to routers/NIs, link-enable writes)

---
 rtl/noc_conf_pkg.sv | 36 +++
 rtl/noc_rr_arbiter.sv | 29 ++
 rtl/noc_conf_bus_arbiter.sv | 140 ++++++++++++++
 tb/tb_noc_conf_bus_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_conf_pkg.sv
// rtl/noc_conf_pkg.sv - shared types and widths for the NoC configuration bus
package noc_conf_pkg;

    localparam int CONF_X         = 3;
    localparam int CONF_Y         = 3;
    localparam int NODES          = CONF_X * CONF_Y;
    localparam int CONF_MAX_PORTS = 8;
    localparam int CONF_LUT_SIZE  = 8;

    localparam int CONF_DATA_W = $clog2(CONF_MAX_PORTS + 1);
    localparam int CONF_SEL_W  = $clog2(CONF_MAX_PORTS);
    localparam int CONF_SLOT_W = $clog2(CONF_LUT_SIZE);
    localparam int CONF_NODE_W = $clog2(NODES);

    typedef enum logic [1:0] {
        LUT_RTR = 2'd0,
        LUT_NI  = 2'd1,
        LINK_EN = 2'd2
    } conf_kind_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } conf_state_t;

    typedef struct packed {
        conf_kind_t               kind;
        logic [CONF_NODE_W-1:0]   node;
        logic [CONF_SEL_W-1:0]    sel;
        logic [CONF_SLOT_W-1:0]   slot;
        logic [CONF_DATA_W-1:0]   data;
        logic                     lock;
    } conf_req_t;

endpackage

// File: rtl/noc_rr_arbiter.sv
// rtl/noc_rr_arbiter.sv - combinational round-robin one-hot picker starting at ptr
module noc_rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int i = 0; i < N; i++) begin
            int c;
            c = int'(ptr) + i;
            if (c >= N) c = c - N;
            if (!any && req[c]) begin
                any       = 1'b1;
                grant[c]  = 1'b1;
                grant_idx = IW'(c);
            end
        end
    end

endmodule

// File: rtl/noc_conf_bus_arbiter.sv
// rtl/noc_conf_bus_arbiter.sv - NoC config bus arbiter: round-robin/locked grant, one strobe per write, post-strobe gap
module noc_conf_bus_arbiter
    import noc_conf_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int X          = 3,
    parameter int Y          = 3,
    parameter int MAX_PORTS  = 8,
    parameter int LUT_SIZE   = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic                                    clk_noc,
    input  logic                                    rst_noc,
    input  logic [NREQ-1:0]                         req_valid,
    output logic [NREQ-1:0]                         req_ready,
    input  conf_req_t [NREQ-1:0]                    req,
    output logic [$clog2(MAX_PORTS+1)-1:0]          lut_conf_data,
    output logic [$clog2(MAX_PORTS)-1:0]            lut_conf_sel,
    output logic [$clog2(LUT_SIZE)-1:0]             lut_conf_slot,
    output logic [$clog2(X*Y)-1:0]                  config_node,
    output logic                                    lut_conf_valid,
    output logic                                    lut_conf_valid_ni,
    output logic                                    link_en_valid,
    output logic                                    busy,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] grant_id,
    output logic [15:0]                             wr_cnt,
    output logic [7:0]                              err_cnt
);

    localparam int GW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int GCW     = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int N_NODES = X * Y;

    conf_state_t     state;
    logic [GW-1:0]   rr_ptr;
    logic [GW-1:0]   lock_owner;
    logic            lock_held;
    logic [GCW-1:0]  gap_cnt;

    logic [NREQ-1:0] owner_mask;
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] pick;
    logic [GW-1:0]   pick_idx;
    logic            pick_any;
    logic            accept;
    logic            win_legal;
    logic            win_kind_ok;
    conf_req_t       win;

    always_comb begin
        owner_mask             = '0;
        owner_mask[lock_owner] = 1'b1;
    end

    // While a burst is locked, the owner is the only candidate; others simply wait.
    assign eligible = lock_held ? (req_valid & owner_mask) : req_valid;

    noc_rr_arbiter #(
        .N  (NREQ),
        .IW (GW)
    ) u_rr (
        .req       (eligible),
        .ptr       (rr_ptr),
        .grant     (pick),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    assign accept      = (state == ST_IDLE) && pick_any;
    assign req_ready   = (state == ST_IDLE) ? pick : '0;
    assign win         = req[pick_idx];
    assign win_legal   = int'(win.node) < N_NODES;
    assign win_kind_ok = win.kind inside {LUT_RTR, LUT_NI, LINK_EN};
    assign busy        = (state != ST_IDLE) || lock_held;

    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            state             <= ST_IDLE;
            rr_ptr            <= '0;
            lock_owner        <= '0;
            lock_held         <= 1'b0;
            gap_cnt           <= '0;
            grant_id          <= '0;
            lut_conf_data     <= '0;
            lut_conf_sel      <= '0;
            lut_conf_slot     <= '0;
            config_node       <= '0;
            lut_conf_valid    <= 1'b0;
            lut_conf_valid_ni <= 1'b0;
            link_en_valid     <= 1'b0;
            wr_cnt            <= '0;
            err_cnt           <= '0;
        end else begin
            lut_conf_valid    <= 1'b0;
            lut_conf_valid_ni <= 1'b0;
            link_en_valid     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        grant_id      <= pick_idx;
                        rr_ptr        <= (int'(pick_idx) == NREQ - 1) ? '0 : pick_idx + 1'b1;
                        lock_held     <= win.lock;
                        lock_owner    <= pick_idx;
                        lut_conf_data <= win.data;
                        lut_conf_sel  <= win.sel;
                        lut_conf_slot <= win.slot;
                        config_node   <= win.node;
                        // Out-of-mesh targets still walk the FSM so pacing is unchanged.
                        if (win_legal) begin
                            case (win.kind)
                                LUT_RTR: lut_conf_valid    <= 1'b1;
                                LUT_NI:  lut_conf_valid_ni <= 1'b1;
                                LINK_EN: link_en_valid     <= 1'b1;
                                default: ;
                            endcase
                            if (win_kind_ok && wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
                        end else if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (GAP_CYCLES == 0) begin
                        state <= ST_IDLE;
                    end else begin
                        state   <= ST_GAP;
                        gap_cnt <= GCW'(GAP_CYCLES - 1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) state <= ST_IDLE;
                    else gap_cnt <= gap_cnt - 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_conf_bus_arbiter.sv
// tb/tb_noc_conf_bus_arbiter.sv - scoreboard bench for noc_conf_bus_arbiter
module tb_noc_conf_bus_arbiter;
    import noc_conf_pkg::*;

    localparam int NREQ = 2;
    localparam int GAP  = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    conf_req_t [NREQ-1:0]   req;
    logic [CONF_DATA_W-1:0] lut_conf_data;
    logic [CONF_SEL_W-1:0]  lut_conf_sel;
    logic [CONF_SLOT_W-1:0] lut_conf_slot;
    logic [CONF_NODE_W-1:0] config_node;
    logic                   lut_conf_valid, lut_conf_valid_ni, link_en_valid, busy;
    logic [0:0]             grant_id;
    logic [15:0]            wr_cnt;
    logic [7:0]             err_cnt;

    noc_conf_bus_arbiter #(.NREQ(NREQ), .GAP_CYCLES(GAP)) u_dut (
        .clk_noc(clk), .rst_noc(rst), .req_valid(req_valid), .req_ready(req_ready), .req(req),
        .lut_conf_data(lut_conf_data), .lut_conf_sel(lut_conf_sel), .lut_conf_slot(lut_conf_slot),
        .config_node(config_node), .lut_conf_valid(lut_conf_valid), .lut_conf_valid_ni(lut_conf_valid_ni),
        .link_en_valid(link_en_valid), .busy(busy), .grant_id(grant_id), .wr_cnt(wr_cnt), .err_cnt(err_cnt)
    );

    logic [0:0]             v1, r1;
    conf_req_t [0:0]        req1;
    logic [CONF_DATA_W-1:0] d1;
    logic [CONF_SEL_W-1:0]  s1;
    logic [CONF_SLOT_W-1:0] sl1;
    logic [CONF_NODE_W-1:0] n1;
    logic                   lv1, lvn1, lev1, busy1;
    logic [0:0]             gid1;
    logic [15:0]            wr1;
    logic [7:0]             err1;

    noc_conf_bus_arbiter #(.NREQ(1), .GAP_CYCLES(0)) u_dut1 (
        .clk_noc(clk), .rst_noc(rst), .req_valid(v1), .req_ready(r1), .req(req1),
        .lut_conf_data(d1), .lut_conf_sel(s1), .lut_conf_slot(sl1), .config_node(n1),
        .lut_conf_valid(lv1), .lut_conf_valid_ni(lvn1), .link_en_valid(lev1), .busy(busy1),
        .grant_id(gid1), .wr_cnt(wr1), .err_cnt(err1)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic conf_req_t mk(input int kind, input int node, input int sel,
                                     input int slot, input int data, input bit lock);
        conf_req_t r;
        r.kind = conf_kind_t'(kind[1:0]);
        r.node = CONF_NODE_W'(node);
        r.sel  = CONF_SEL_W'(sel);
        r.slot = CONF_SLOT_W'(slot);
        r.data = CONF_DATA_W'(data);
        r.lock = lock;
        return r;
    endfunction

    // Reference model: per-requester pending queues, plain round-robin arithmetic.
    typedef struct { conf_req_t r; int g; } exp_t;
    conf_req_t pend[NREQ][$];
    exp_t      sb[$];
    int m_rr = 0, m_lock = -1, m_wait = 0, m_wr = 0, m_err = 0;
    bit drop_en = 1'b0;
    int mon_strobes = 0;

    task automatic model_reset();
        m_rr = 0; m_lock = -1; m_wait = 0; m_wr = 0; m_err = 0;
        for (int r = 0; r < NREQ; r++) pend[r].delete();
        sb.delete();
    endtask

    task automatic step();
        logic [NREQ-1:0] v;
        int g;
        bit idle, exp_busy;
        conf_req_t h;
        @(posedge clk);
        #1;
        for (int r = 0; r < NREQ; r++) begin
            v[r]   = (pend[r].size() > 0) && !(drop_en && $urandom_range(0, 3) == 0);
            req[r] = (pend[r].size() > 0) ? pend[r][0] : '0;
        end
        req_valid = v;
        idle = (m_wait == 0);
        exp_busy = !idle || (m_lock >= 0);
        if (!idle) m_wait--;
        g = -1;
        if (idle) begin
            for (int i = 0; i < NREQ; i++) begin
                int c;
                c = (m_rr + i) % NREQ;
                if (g < 0 && v[c] && (m_lock < 0 || m_lock == c)) g = c;
            end
        end
        @(negedge clk);
        chk("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
        chk("busy", 32'(busy), 32'(exp_busy));
        if (g >= 0) begin
            h = pend[g].pop_front();
            if (int'(h.node) < NODES) begin
                sb.push_back('{r: h, g: g});
                m_wr++;
            end else begin
                m_err++;
            end
            m_rr   = (g + 1) % NREQ;
            m_lock = h.lock ? g : -1;
            m_wait = 1 + GAP;
        end
    endtask

    initial begin
        exp_t e;
        int n, k;
        forever begin
            @(negedge clk);
            n = int'(lut_conf_valid) + int'(lut_conf_valid_ni) + int'(link_en_valid);
            if (!rst && n != 0) begin
                mon_strobes++;
                chk("one_strobe", 32'(n), 32'd1);
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_strobe actual=strobe required=none");
                end else begin
                    e = sb.pop_front();
                    k = lut_conf_valid ? 0 : (lut_conf_valid_ni ? 1 : 2);
                    chk("kind", 32'(k), 32'(e.r.kind));
                    chk("config_node", 32'(config_node), 32'(e.r.node));
                    chk("lut_conf_sel", 32'(lut_conf_sel), 32'(e.r.sel));
                    chk("lut_conf_slot", 32'(lut_conf_slot), 32'(e.r.slot));
                    chk("lut_conf_data", 32'(lut_conf_data), 32'(e.r.data));
                    chk("grant_id", 32'(grant_id), 32'(e.g));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, guard;
        req_valid = '0;
        req = '0;
        v1 = 1'b0;
        req1[0] = mk(0, 1, 1, 1, 1, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_cnt", 32'(wr_cnt), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_strobes", {29'd0, lut_conf_valid, lut_conf_valid_ni, link_en_valid}, 32'd0);
        chk("rst_config_node", 32'(config_node), 32'd0);
        rst = 1'b0;

        // single write
        pend[0].push_back(mk(0, 4, 2, 5, 3, 1'b0));
        step();
        step();
        chk("single_strobe", 32'(lut_conf_valid), 32'd1);
        chk("single_wr_cnt", 32'(wr_cnt), 32'd1);
        step();
        chk("single_strobe_gone", 32'(lut_conf_valid), 32'd0);
        chk("single_hold_node", 32'(config_node), 32'd4);

        // reset asserted during ISSUE
        pend[1].push_back(mk(2, 7, 1, 2, 8, 1'b1));
        step();
        step();
        #1 rst = 1'b1;
        #1;
        chk("midrst_strobes", {29'd0, lut_conf_valid, lut_conf_valid_ni, link_en_valid}, 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_wr_cnt", 32'(wr_cnt), 32'd0);
        chk("midrst_node", 32'(config_node), 32'd0);
        chk("midrst_grant", 32'(grant_id), 32'd0);
        model_reset();
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;

        // round-robin with both requesters continuously valid
        for (int i = 0; i < 2; i++) begin
            pend[0].push_back(mk(0, i, i, i, i, 1'b0));
            pend[1].push_back(mk(1, 8 - i, 7 - i, 7 - i, 8 - i, 1'b0));
        end
        base = mon_strobes;
        repeat (12) step();
        chk("rr_strobes_12cyc", 32'(mon_strobes - base), 32'd4);

        // locked 8-beat burst from requester 0 against a waiting requester 1
        for (int i = 0; i < 8; i++) pend[0].push_back(mk(1, i, i, i, i, i < 7));
        pend[1].push_back(mk(2, 3, 3, 3, 3, 1'b0));
        repeat (30) step();

        // illegal node
        pend[1].push_back(mk(2, 9, 1, 1, 1, 1'b0));
        repeat (4) step();
        chk("illegal_err_cnt", 32'(err_cnt), 32'd1);
        chk("illegal_wr_cnt", 32'(wr_cnt), 32'(m_wr));

        // randomized traffic with valid drops and random bursts
        drop_en = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                int r, len;
                r = $urandom_range(0, NREQ - 1);
                len = $urandom_range(1, 4);
                if (pend[r].size() < 6) begin
                    for (int b = 0; b < len; b++)
                        pend[r].push_back(mk($urandom_range(0, 2), $urandom_range(0, 11),
                                             $urandom_range(0, 7), $urandom_range(0, 7),
                                             $urandom_range(0, 8), b < len - 1));
                end
            end
            step();
        end
        guard = 0;
        while ((pend[0].size() > 0 || pend[1].size() > 0 || m_wait != 0) && guard < 600) begin
            step();
            guard++;
        end
        if (guard >= 600) begin
            checks++;
            failures++;
            $display("FAIL drain actual=pending required=empty");
        end
        step();
        drop_en = 1'b0;
        chk("final_wr_cnt", 32'(wr_cnt), 32'(m_wr));
        chk("final_err_cnt", 32'(err_cnt), 32'(m_err));
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        // single requester, zero gap: strobe every second cycle, then saturation
        @(negedge clk);
        v1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("gap0_strobe", 32'(lv1), 32'(i % 2 == 0));
            chk("gap0_ready", 32'(r1), 32'(i % 2 == 1));
        end
        v1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("gap0_wr_cnt", 32'(wr1), 32'd4);
        force u_dut1.wr_cnt = 16'hFFFD;
        #1;
        release u_dut1.wr_cnt;
        @(negedge clk);
        v1 = 1'b1;
        repeat (6) @(negedge clk);
        v1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("wr_cnt_saturate", 32'(wr1), 32'h0000FFFF);
        chk("gap0_err_cnt", 32'(err1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
